// File: rtl/any1_issue_sched.sv
// Multi-port issue scheduler: wakes ready ROB entries and offers up to NPORTS of them,
// branches first then oldest first. Optional starvation guard: ANY1_SCHED_STARVE_EN.
module any1_issue_sched #(
   parameter int RENTRIES   = 64,
   parameter int RIDW       = 6,
   parameter int NPORTS     = 2,
   parameter int STARVE_LIM = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [RIDW-1:0]          head_i,
   input  logic [RENTRIES-1:0]      rdy_i,
   input  logic [RENTRIES-1:0]      memop_i,
   input  logic [RENTRIES-1:0]      memblk_i,
   input  logic [RENTRIES-1:0]      branch_i,
   input  logic [RENTRIES-1:0]      out_i,
   input  logic                     flush_i,
   input  logic [NPORTS-1:0]        iss_ack_i,
   output logic [NPORTS-1:0]        iss_v_o,
   output logic [NPORTS*RIDW-1:0]   iss_rid_o,
   output logic [RENTRIES-1:0]      wakeup_o,
   output logic                     busy_o
);

   logic [NPORTS-1:0]   iss_v_reg, iss_v_next;
   logic [RIDW-1:0]     iss_rid_reg  [NPORTS];
   logic [RIDW-1:0]     iss_rid_next [NPORTS];
   logic [RENTRIES-1:0] pending_reg, pending_next, wakeup_reg;
   logic [RENTRIES-1:0] offered, set_mask, blocked, woke;
   logic [NPORTS-1:0]   acked, hold_port;
   logic                held_mem;
   logic                force_old;
   logic [RIDW-1:0]     old_rid;
   logic [RIDW-1:0]     pick [NPORTS];
   logic [RIDW-1:0]     idx;
   logic                mem_taken, seen_blk;
   int                  nfree, pick_cnt, slot;

   generate
      for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
         assign acked[gi]     = iss_v_reg[gi] & iss_ack_i[gi];
         assign hold_port[gi] = iss_v_reg[gi] & ~iss_ack_i[gi];
         assign iss_rid_o[gi*RIDW +: RIDW] = iss_rid_reg[gi];
      end
   endgenerate

   // Entries on a port this cycle are excluded whether held or just acked,
   // since an acked entry only shows up in pending one cycle later.
   always_comb begin
      offered  = '0;
      set_mask = '0;
      held_mem = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         if (iss_v_reg[p]) offered[iss_rid_reg[p]] = 1'b1;
         if (acked[p] && !flush_i) set_mask[iss_rid_reg[p]] = 1'b1;
         if (hold_port[p] && memop_i[iss_rid_reg[p]]) held_mem = 1'b1;
      end
   end

   // Walking in age order, a mem op is blocked by any older memblk entry.
   always_comb begin
      blocked  = '0;
      seen_blk = 1'b0;
      for (int k = 0; k < RENTRIES; k++) begin
         blocked[head_i + RIDW'(k)] = seen_blk;
         seen_blk = seen_blk | memblk_i[head_i + RIDW'(k)];
      end
   end

   assign woke = rdy_i & ~pending_reg & ~offered & ~(memop_i & blocked);

`ifdef ANY1_SCHED_STARVE_EN
   logic            old_v, old_placed;
   logic [3:0]      starve_reg, starve_next;
   logic [RIDW-1:0] old_rid_reg;

   always_comb begin
      old_v   = 1'b0;
      old_rid = '0;
      for (int k = 0; k < RENTRIES; k++) begin
         if (!old_v && woke[head_i + RIDW'(k)]) begin
            old_v   = 1'b1;
            old_rid = head_i + RIDW'(k);
         end
      end
   end

   assign force_old = old_v && (old_rid == old_rid_reg) && (starve_reg >= 4'(STARVE_LIM))
                      && !(memop_i[old_rid] && held_mem);

   always_comb begin
      old_placed = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
         if (!hold_port[p] && iss_v_next[p] && iss_rid_next[p] == old_rid) old_placed = 1'b1;
      end
      starve_next = starve_reg;
      if (old_v) begin
         if (old_placed)               starve_next = 4'd0;
         else if (old_rid != old_rid_reg) starve_next = 4'd1;
         else if (starve_reg != 4'hF)  starve_next = starve_reg + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         starve_reg  <= 4'd0;
         old_rid_reg <= '0;
      end else begin
         starve_reg  <= starve_next;
         if (old_v) old_rid_reg <= old_rid;
      end
   end
`else
   assign force_old = 1'b0;
   assign old_rid   = '0;
`endif

   always_comb begin
      nfree     = 0;
      pick_cnt  = 0;
      slot      = 0;
      idx       = '0;
      mem_taken = held_mem;
      for (int p = 0; p < NPORTS; p++) begin
         pick[p] = '0;
         if (!hold_port[p]) nfree = nfree + 1;
      end
      if (force_old && nfree > 0) begin
         pick[0]   = old_rid;
         pick_cnt  = 1;
         mem_taken = mem_taken | memop_i[old_rid];
      end
      // Pass 0 collects branches, pass 1 the rest, each in ascending age.
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < RENTRIES; k++) begin
            idx = head_i + RIDW'(k);
            if (woke[idx] && (branch_i[idx] == (pass == 0)) && pick_cnt < nfree
                && !(memop_i[idx] && mem_taken) && !(force_old && idx == old_rid)) begin
               pick[pick_cnt] = idx;
               pick_cnt       = pick_cnt + 1;
               if (memop_i[idx]) mem_taken = 1'b1;
            end
         end
      end
      for (int p = 0; p < NPORTS; p++) begin
         iss_v_next[p]   = 1'b0;
         iss_rid_next[p] = iss_rid_reg[p];
         if (hold_port[p]) begin
            iss_v_next[p] = 1'b1;
         end else if (slot < pick_cnt) begin
            iss_v_next[p]   = 1'b1;
            iss_rid_next[p] = pick[slot];
            slot            = slot + 1;
         end
      end
   end

   assign pending_next = flush_i ? '0 : ((pending_reg | set_mask) & ~out_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         iss_v_reg   <= '0;
         pending_reg <= '0;
         wakeup_reg  <= '0;
         for (int p = 0; p < NPORTS; p++) iss_rid_reg[p] <= '0;
      end else begin
         iss_v_reg   <= flush_i ? '0 : iss_v_next;
         pending_reg <= pending_next;
         wakeup_reg  <= woke;
         for (int p = 0; p < NPORTS; p++) iss_rid_reg[p] <= iss_rid_next[p];
      end
   end

   assign iss_v_o  = iss_v_reg;
   assign wakeup_o = wakeup_reg;
   assign busy_o   = (|iss_v_reg) | (|pending_reg);

endmodule

// File: tb/tb_any1_issue_sched.sv
// Directed-vector bench for any1_issue_sched in its default build (RENTRIES=64, NPORTS=2).
module tb_any1_issue_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  head;
   logic [63:0] rdy, memop, memblk, branch, outv;
   logic        flush;
   logic [1:0]  ack;
   logic [1:0]  iss_v;
   logic [11:0] iss_rid;
   logic [63:0] wakeup;
   logic        busy;
   logic [5:0]  rid0, rid1;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   assign rid0 = iss_rid[5:0];
   assign rid1 = iss_rid[11:6];

   any1_issue_sched #(.RENTRIES(64), .RIDW(6), .NPORTS(2), .STARVE_LIM(15)) dut (
      .clk_i(clk), .rst_i(rst), .head_i(head), .rdy_i(rdy), .memop_i(memop),
      .memblk_i(memblk), .branch_i(branch), .out_i(outv), .flush_i(flush),
      .iss_ack_i(ack), .iss_v_o(iss_v), .iss_rid_o(iss_rid), .wakeup_o(wakeup), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d: v=%b rid0=%0d rid1=%0d wakeup=%h busy=%b", cyc, iss_v, rid0, rid1, wakeup, busy);
   endtask

   task automatic clear_inputs();
      head = 6'd0; rdy = '0; memop = '0; memblk = '0; branch = '0; outv = '0;
      flush = 1'b0; ack = 2'b00;
   endtask

   task automatic do_flush();
      clear_inputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1; rdy = 64'hFF; flush = 1'b1; ack = 2'b11;
      step(); step();
      vectors++; if (iss_v !== 2'b00) begin miscompares++; $display("FAIL reset_v got %b want 00", iss_v); end
      vectors++; if (iss_rid !== 12'd0) begin miscompares++; $display("FAIL reset_rid got %h want 000", iss_rid); end
      vectors++; if (wakeup !== 64'd0) begin miscompares++; $display("FAIL reset_wakeup got %h want 0", wakeup); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_basic();
      do_flush();
      head = 6'd0; rdy = 64'h0C; ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b11) begin miscompares++; $display("FAIL basic_v got %b want 11", iss_v); end
      vectors++; if (rid0 !== 6'd2 || rid1 !== 6'd3) begin miscompares++; $display("FAIL basic_rid got %0d,%0d want 2,3", rid0, rid1); end
      vectors++; if (wakeup !== 64'h0C) begin miscompares++; $display("FAIL basic_wakeup got %h want c", wakeup); end
      step();
      vectors++; if (iss_v !== 2'b00) begin miscompares++; $display("FAIL basic_nodup_v got %b want 00", iss_v); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_pend got %b want 1", busy); end
      rdy = '0; outv = 64'h0C;
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_clr got %b want 0", busy); end
      outv = '0;
   endtask

   task automatic test_branch_first();
      do_flush();
      head = 6'd4; rdy = (64'd1 << 5) | (64'd1 << 9); branch = 64'd1 << 9; ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b11) begin miscompares++; $display("FAIL branch_v got %b want 11", iss_v); end
      vectors++; if (rid0 !== 6'd9 || rid1 !== 6'd5) begin miscompares++; $display("FAIL branch_rid got %0d,%0d want 9,5", rid0, rid1); end
   endtask

   task automatic test_wrap();
      do_flush();
      head = 6'd60; rdy = (64'd1 << 62) | (64'd1 << 1); ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b11) begin miscompares++; $display("FAIL wrap_v got %b want 11", iss_v); end
      vectors++; if (rid0 !== 6'd62 || rid1 !== 6'd1) begin miscompares++; $display("FAIL wrap_rid got %0d,%0d want 62,1", rid0, rid1); end
   endtask

   task automatic test_back_to_back();
      do_flush();
      head = 6'd2; rdy = 64'h0E; ack = 2'b11;
      step();
      vectors++; if (rid0 !== 6'd2 || rid1 !== 6'd3 || iss_v !== 2'b11) begin miscompares++; $display("FAIL b2b_first got v=%b %0d,%0d want v=11 2,3", iss_v, rid0, rid1); end
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd1) begin miscompares++; $display("FAIL b2b_second got v=%b rid0=%0d want v=01 rid0=1", iss_v, rid0); end
      step();
      vectors++; if (iss_v !== 2'b00) begin miscompares++; $display("FAIL b2b_drain got %b want 00", iss_v); end
   endtask

   task automatic test_mem_order();
      do_flush();
      head = 6'd0; memop = 64'h88; memblk = 64'h08; rdy = 64'h88; ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd3) begin miscompares++; $display("FAIL mem_first got v=%b rid0=%0d want v=01 rid0=3", iss_v, rid0); end
      vectors++; if (wakeup !== 64'h08) begin miscompares++; $display("FAIL mem_wakeup got %h want 8", wakeup); end
      step();
      vectors++; if (iss_v !== 2'b00) begin miscompares++; $display("FAIL mem_blocked got %b want 00", iss_v); end
      memblk = '0; outv = 64'h08; rdy = 64'h80;
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd7) begin miscompares++; $display("FAIL mem_release got v=%b rid0=%0d want v=01 rid0=7", iss_v, rid0); end
      outv = '0;
   endtask

   task automatic test_mem_single();
      do_flush();
      head = 6'd0; memop = 64'h30; rdy = 64'h30; ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd4) begin miscompares++; $display("FAIL mem1_first got v=%b rid0=%0d want v=01 rid0=4", iss_v, rid0); end
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd5) begin miscompares++; $display("FAIL mem1_second got v=%b rid0=%0d want v=01 rid0=5", iss_v, rid0); end
   endtask

   task automatic test_hold_flush();
      do_flush();
      head = 6'd0; rdy = 64'h10; ack = 2'b00;
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd4) begin miscompares++; $display("FAIL hold_offer got v=%b rid0=%0d want v=01 rid0=4", iss_v, rid0); end
      for (int n = 0; n < 5; n++) begin
         step();
         vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd4) begin miscompares++; $display("FAIL hold_stable%0d got v=%b rid0=%0d want v=01 rid0=4", n, iss_v, rid0); end
      end
      rdy = 64'h50;
      step();
      vectors++; if (iss_v !== 2'b11 || rid0 !== 6'd4 || rid1 !== 6'd6) begin miscompares++; $display("FAIL hold_refill got v=%b %0d,%0d want v=11 4,6", iss_v, rid0, rid1); end
      flush = 1'b1; ack = 2'b11;
      step();
      vectors++; if (iss_v !== 2'b00) begin miscompares++; $display("FAIL flush_v got %b want 00", iss_v); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b want 0", busy); end
      flush = 1'b0; ack = 2'b00; rdy = 64'h10;
      step();
      vectors++; if (iss_v !== 2'b01 || rid0 !== 6'd4) begin miscompares++; $display("FAIL flush_reissue got v=%b rid0=%0d want v=01 rid0=4", iss_v, rid0); end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_branch_first();
      test_wrap();
      test_back_to_back();
      test_mem_order();
      test_mem_single();
      test_hold_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
